// File: rtl/fc3_mac_engine.sv
`default_nettype none
// ============================================================================
// Module   : fc3_mac_engine
// Purpose  : fc3 layer MAC engine. Streams activations against a packed weight
//            ROM and accumulates one logit per neuron. Optional argmax stage is
//            enabled with macro FC3_ARGMAX_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fc3_mac_engine #(
    parameter int NUM_INPUTS   = 16,
    parameter int NUM_NEURONS  = 10,
    parameter int ACT_WIDTH    = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACC_WIDTH    = 32,
    parameter int ADDR_WIDTH   = $clog2(NUM_INPUTS),
    parameter int CLASS_WIDTH  = $clog2(NUM_NEURONS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [ACT_WIDTH-1:0]              in_data,
    output logic [ADDR_WIDTH-1:0]             rom_addr,
    input  logic [NUM_NEURONS*WEIGHT_WIDTH-1:0] rom_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NUM_NEURONS*ACC_WIDTH-1:0]  out_data,
    output logic [CLASS_WIDTH-1:0]            out_class,
    output logic                              busy
);

    localparam int                    c_prod_w    = ACT_WIDTH + WEIGHT_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_last_feat = ADDR_WIDTH'(NUM_INPUTS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_ARGMAX = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                       r_state;
    logic [ADDR_WIDTH-1:0]        r_feat_cnt;
    logic signed [ACC_WIDTH-1:0]  r_acc [NUM_NEURONS];
    logic signed [ACC_WIDTH-1:0]  w_prod_ext [NUM_NEURONS];
    logic signed [ACT_WIDTH-1:0]  w_act;
    logic                         w_accept;
    logic                         w_last_beat;

    assign w_act       = in_data;
    assign in_ready    = (r_state == S_IDLE) || (r_state == S_ACCUM);
    assign w_accept    = in_valid && in_ready;
    assign w_last_beat = w_accept && (r_feat_cnt == c_last_feat);
    assign rom_addr    = r_feat_cnt;
    assign out_valid   = (r_state == S_DONE);
    assign busy        = (r_state != S_IDLE);

    generate
        for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_neuron
            logic signed [WEIGHT_WIDTH-1:0] w_weight;
            logic signed [c_prod_w-1:0]     w_prod;
            assign w_weight       = rom_data[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            assign w_prod         = w_act * w_weight;
            assign w_prod_ext[gi] = ACC_WIDTH'(w_prod);
            assign out_data[gi*ACC_WIDTH +: ACC_WIDTH] = r_acc[gi];
        end
    endgenerate

    // Feature 0 overwrites the accumulators, so no separate clear cycle is needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_feat_cnt <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                r_acc[i] <= '0;
            end
        end else if (w_accept) begin
            r_feat_cnt <= (r_feat_cnt == c_last_feat) ? '0 : r_feat_cnt + ADDR_WIDTH'(1);
            for (int i = 0; i < NUM_NEURONS; i++) begin
                r_acc[i] <= (r_feat_cnt == '0) ? w_prod_ext[i] : r_acc[i] + w_prod_ext[i];
            end
        end
    end

`ifdef FC3_ARGMAX_EN
    localparam logic [CLASS_WIDTH-1:0] c_last_neuron = CLASS_WIDTH'(NUM_NEURONS - 1);

    logic [CLASS_WIDTH-1:0]       r_scan;
    logic [CLASS_WIDTH-1:0]       r_best_idx;
    logic signed [ACC_WIDTH-1:0]  r_best_val;

    assign out_class = r_best_idx;

    // Strict greater-than keeps the lowest index on ties.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_scan     <= '0;
            r_best_idx <= '0;
            r_best_val <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) r_state <= S_ACCUM;
                end
                S_ACCUM: begin
                    if (w_last_beat) begin
                        r_state <= S_ARGMAX;
                        r_scan  <= '0;
                    end
                end
                S_ARGMAX: begin
                    if (r_scan == '0 || r_acc[r_scan] > r_best_val) begin
                        r_best_idx <= r_scan;
                        r_best_val <= r_acc[r_scan];
                    end
                    if (r_scan == c_last_neuron) begin
                        r_state <= S_DONE;
                    end else begin
                        r_scan <= r_scan + CLASS_WIDTH'(1);
                    end
                end
                default: begin
                    if (out_ready) r_state <= S_IDLE;
                end
            endcase
        end
    end
`else
    assign out_class = '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) r_state <= S_ACCUM;
                end
                S_ACCUM: begin
                    if (w_last_beat) r_state <= S_DONE;
                end
                default: begin
                    if (out_ready) r_state <= S_IDLE;
                end
            endcase
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fc3_mac_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_fc3_mac_engine
// Purpose  : Self-checking bench for fc3_mac_engine: directed table vectors,
//            reset corner case and randomized vectors against a sum model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fc3_mac_engine;

    localparam int NI = 16;
    localparam int NN = 10;
    localparam int CW = 32;
`ifdef FC3_ARGMAX_EN
    localparam int LAT    = NN + 1;
    localparam bit HAS_AM = 1'b1;
`else
    localparam int LAT    = 1;
    localparam bit HAS_AM = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [7:0]   in_data = 8'h00;
    logic         in_ready;
    logic [3:0]   rom_addr;
    logic [79:0]  rom_data;
    logic         out_valid;
    logic [319:0] out_data;
    logic [3:0]   out_class;
    logic         busy;

    logic [79:0]  rom [NI];
    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    fc3_mac_engine dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_class (out_class),
        .busy      (busy)
    );

    typedef struct {
        logic signed [7:0] act;
        bit                w_lane_idx;
        logic signed [7:0] w_const;
        bit                gaps;
        int                hold;
        longint            exp_base;
        longint            exp_step;
        int                exp_class;
    } vec_t;

    vec_t              tbl [6];
    logic signed [7:0] acts [NI];
    longint            exp_lane [NN];
    int                exp_cls;
    int                n_checks = 0;
    int                n_fail   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_rom(input bit lane_idx, input logic signed [7:0] c);
        for (int a = 0; a < NI; a++)
            for (int i = 0; i < NN; i++)
                rom[a][i*8 +: 8] = lane_idx ? 8'(i) : c;
    endtask

    // Reference: plain dot products per neuron, then first maximum.
    task automatic model_from_rom();
        longint best;
        for (int i = 0; i < NN; i++) begin
            exp_lane[i] = 0;
            for (int k = 0; k < NI; k++)
                exp_lane[i] += longint'(acts[k]) * longint'($signed(rom[k][i*8 +: 8]));
        end
        best = exp_lane[0];
        exp_cls = 0;
        for (int i = 1; i < NN; i++)
            if (exp_lane[i] > best) begin
                best = exp_lane[i];
                exp_cls = i;
            end
        if (!HAS_AM) exp_cls = 0;
    endtask

    task automatic check_result(input string tag);
        for (int i = 0; i < NN; i++)
            chk($sformatf("%s_lane%0d", tag, i), longint'($signed(out_data[i*CW +: CW])), exp_lane[i]);
        chk({tag, "_class"}, longint'(out_class), longint'(exp_cls));
    endtask

    task automatic send_beats(input int n, input bit gaps);
        for (int k = 0; k < n; k++) begin
            if (gaps) begin
                in_valid = 1'b0;
                in_data  = 8'h55;
                @(posedge clk); #1;
                chk("addr_hold", longint'(rom_addr), longint'(k));
            end
            chk("rom_addr", longint'(rom_addr), longint'(k));
            in_valid = 1'b1;
            in_data  = acts[k];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_vector(input bit gaps, input int hold);
        int cyc;
        send_beats(NI, gaps);
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("out_valid", longint'(out_valid), 1);
        chk("latency", longint'(cyc), longint'(LAT));
        chk("done_in_ready", longint'(in_ready), 0);
        chk("done_busy", longint'(busy), 1);
        check_result("res");
        if (hold > 0) begin
            out_ready = 1'b0;
            for (int h = 0; h < hold; h++) begin
                in_valid = 1'b1;
                in_data  = 8'($urandom);
                @(posedge clk); #1;
                chk("hold_valid", longint'(out_valid), 1);
                chk("hold_in_ready", longint'(in_ready), 0);
                check_result("hold");
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("post_valid", longint'(out_valid), 0);
        chk("post_in_ready", longint'(in_ready), 1);
        chk("post_busy", longint'(busy), 0);
    endtask

    initial begin
        tbl[0] = '{8'sd1,  1'b1, 8'sd0,  1'b0, 0, 64'sd0,      64'sd16, 9};
        tbl[1] = '{8'h80,  1'b0, 8'h80,  1'b0, 0, 64'sd262144, 64'sd0,  0};
        tbl[2] = '{8'sd1,  1'b1, 8'sd0,  1'b1, 0, 64'sd0,      64'sd16, 9};
        tbl[3] = '{8'sd1,  1'b1, 8'sd0,  1'b0, 5, 64'sd0,      64'sd16, 9};
        tbl[4] = '{8'sd2,  1'b1, 8'sd0,  1'b0, 0, 64'sd0,      64'sd32, 9};
        tbl[5] = '{8'sd1,  1'b1, 8'sd0,  1'b0, 0, 64'sd0,      64'sd16, 9};

        load_rom(1'b1, 8'sd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_rom_addr", longint'(rom_addr), 0);
        chk("rst_out_data", longint'(out_data == '0), 1);
        chk("rst_out_class", longint'(out_class), 0);
        rst = 1'b0;

        for (int t = 0; t < 6; t++) begin
            load_rom(tbl[t].w_lane_idx, tbl[t].w_const);
            for (int k = 0; k < NI; k++) acts[k] = tbl[t].act;
            for (int i = 0; i < NN; i++) exp_lane[i] = tbl[t].exp_base + tbl[t].exp_step * i;
            exp_cls = HAS_AM ? tbl[t].exp_class : 0;
            run_vector(tbl[t].gaps, tbl[t].hold);
        end

        // Reset after 7 beats discards the partial vector.
        load_rom(1'b1, 8'sd0);
        for (int k = 0; k < NI; k++) acts[k] = 8'sd1;
        send_beats(7, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_valid", longint'(out_valid), 0);
        chk("midrst_busy", longint'(busy), 0);
        chk("midrst_addr", longint'(rom_addr), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_valid2", longint'(out_valid), 0);
        for (int i = 0; i < NN; i++) exp_lane[i] = 16 * i;
        exp_cls = HAS_AM ? 9 : 0;
        run_vector(1'b0, 0);

        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < NI; a++) rom[a] = {$urandom, $urandom, $urandom};
            for (int k = 0; k < NI; k++) acts[k] = 8'($urandom);
            model_from_rom();
            run_vector(1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fc3_mac_engine.md
# fc3_mac_engine

Final fully-connected (fc3) compute stage. Consumes a stream of 16 signed 8-bit input activations and drives the fc3 weight ROM address. Multiplies each activation by the 10 packed per-neuron weights returned combinationally by the ROM and accumulates one 32-bit logit per neuron. Presents the 10 logits, plus an optional argmax class index, on a valid/ready output.

## Interface
Parameters:
- NUM_INPUTS, 16, input features per vector (ROM depth in packed words)
- NUM_NEURONS, 10, output neurons / classes
- ACT_WIDTH, 8, signed activation width
- WEIGHT_WIDTH, 8, signed weight width
- ACC_WIDTH, 32, signed accumulator width per neuron
- ADDR_WIDTH, $clog2(NUM_INPUTS), ROM address width
- CLASS_WIDTH, $clog2(NUM_NEURONS), class index width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  activation beat valid
- in_ready  out  1  engine accepts a beat
- in_data  in  ACT_WIDTH  signed activation, feature order 0..NUM_INPUTS-1
- rom_addr  out  ADDR_WIDTH  weight ROM address, equals current feature index
- rom_data  in  NUM_NEURONS*WEIGHT_WIDTH  packed weights; lane i (bits i*WEIGHT_WIDTH +: WEIGHT_WIDTH) is neuron i, signed
- out_valid  out  1  logits valid
- out_ready  in  1  downstream accepts logits
- out_data  out  NUM_NEURONS*ACC_WIDTH  packed logits; lane i = neuron i, signed
- out_class  out  CLASS_WIDTH  argmax index (see Configuration)
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ACCUM, ARGMAX (macro only), DONE.
- Beat accepted when in_valid && in_ready. in_ready = 1 in IDLE and ACCUM, 0 otherwise.
- rom_addr = feat_cnt (registered counter). The ROM is asynchronous, so rom_data is consumed in the same cycle as the accepted beat.
- Per accepted beat, for each neuron i: prod_i = signed(in_data) * signed(lane_i), a 16-bit value sign-extended to ACC_WIDTH.
  - feat_cnt == 0: acc_i <= prod_i (overwrite, no clear cycle).
  - Otherwise: acc_i <= acc_i + prod_i.
- Accumulation wraps modulo 2^ACC_WIDTH with no saturation. The worst case (16 × 16384) fits.
- IDLE -> ACCUM on the first accepted beat. ACCUM -> ARGMAX (or DONE) on the accepted beat with feat_cnt == NUM_INPUTS-1. feat_cnt wraps to 0.
- Unaccepted cycles (in_valid low) hold feat_cnt, rom_addr and the accumulators.
- ARGMAX: scan neurons 0..NUM_NEURONS-1, one per cycle, keeping the best index and value. Replace only on strictly greater, so ties resolve to the lowest index.
- DONE: out_valid = 1, with out_data and out_class stable until out_ready. On out_valid && out_ready -> IDLE.
- out_data always reflects the accumulator registers.

## Timing
- Reset values:
  - state IDLE, feat_cnt 0, rom_addr 0
  - in_ready 1, out_valid 0, busy 0
  - all accumulators 0 (out_data 0), out_class 0
- Reset mid-vector or mid-DONE: the partial result is discarded with no out_valid. The next accepted beat is treated as feature 0.
- Without the macro: out_valid rises the cycle after the 16th accepted beat.
- With the macro: out_valid rises NUM_NEURONS+1 cycles after the 16th accepted beat.
- Minimum vector period (out_ready tied high): 17 cycles without the macro, 27 with it. There is no overlap between output hold and next input, because in_ready is low in DONE.
- The cycle of the output handshake returns to IDLE. in_ready is high on the next cycle.
- in_valid asserted while in_ready is low is ignored. in_data need not be held.

## Configuration
- Macro FC3_ARGMAX_EN.
- Defined: the ARGMAX state is present and out_class holds the registered argmax index of the logits, valid with out_valid.
- Undefined: the ARGMAX state and comparator are removed, ACCUM -> DONE directly, and out_class is tied to 0.

## Test plan
- All 16 activations = 1, ROM lane i = i for every address -> lane i = 16*i; out_class = 9 (with macro).
- All activations = -128, all weights = -128 -> every lane = 262144 (0x40000); out_class = 0 (tie, lowest index).
- Test 1 stimulus with in_valid low on every other cycle -> identical result; rom_addr advances only on accepted beats; out_valid 1 cycle after the last beat (11 with macro).
- Hold out_ready low 5 cycles in DONE -> out_valid stays 1, out_data and out_class constant, in_ready 0 and in_valid ignored.
- Assert rst after 7 accepted beats, then send test 1 vector -> no spurious out_valid, and the result equals test 1 exactly.
- Two back-to-back vectors (activations all 2, then all 1, weights lane i = i) with out_ready tied high -> lanes 32*i, then 16*i; no carry-over between vectors.
